regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the CPU's 4×8-bit register file, which has a single write port. Two producers, the ALU (requester 0) and the load unit (requester 1), each push write-back requests over a valid/ready handshake into a private 2-entry queue. A round-robin arbiter drains the queues one write per cycle onto the register file's write port through registered outputs.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file write-back types and sizes.
package cpu_pkg;
    localparam int REG_ADDR_W = 2;
    localparam int REG_DATA_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_t;
endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO holding one requester's pending write-backs.
// Latency: an entry pushed at edge k is visible at head from cycle k+1.
// Backpressure: full is a pure function of the registered count; push while full and pop while empty are ignored.
module wb_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU and load-unit write-backs onto the single register-file write port.
// Latency: accept at edge k, grant at edge k+1 earliest, wr_en high the cycle after, commit at edge k+2.
// Backpressure: reqN_ready drops while queue N holds DEPTH entries; output side never stalls.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);
    localparam int W  = ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  head0, head1, gnt_head;
    logic [CW-1:0] cnt0, cnt1;
    logic          full0, full1, empty0, empty1;
    logic          pop0, pop1;
    logic          gnt_vld;
    req_idx_t      gnt_idx;
    req_idx_t      last_grant;

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_q0 (
        .clk       (clk),
        .reset     (reset),
        .push      (req0_valid & req0_ready),
        .push_data ({req0_addr, req0_data}),
        .pop       (pop0),
        .head      (head0),
        .count     (cnt0),
        .full      (full0),
        .empty     (empty0)
    );

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_q1 (
        .clk       (clk),
        .reset     (reset),
        .push      (req1_valid & req1_ready),
        .push_data ({req1_addr, req1_data}),
        .pop       (pop1),
        .head      (head1),
        .count     (cnt1),
        .full      (full1),
        .empty     (empty1)
    );

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        gnt_vld = ~empty0 | ~empty1;
        gnt_idx = REQ_ALU;
        if (~empty0 & ~empty1)
            gnt_idx = (last_grant == REQ_ALU) ? REQ_LOAD : REQ_ALU;
        else if (empty0)
            gnt_idx = REQ_LOAD;
        pop0     = gnt_vld & (gnt_idx == REQ_ALU);
        pop1     = gnt_vld & (gnt_idx == REQ_LOAD);
        gnt_head = (gnt_idx == REQ_ALU) ? head0 : head1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= REQ_LOAD;
        end else begin
            wr_en <= gnt_vld;
            if (gnt_vld) begin
                wr_addr    <= gnt_head[DATA_W +: ADDR_W];
                wr_data    <= gnt_head[DATA_W-1:0];
                last_grant <= gnt_idx;
            end
        end
    end

    assign busy = (cnt0 != '0) | (cnt1 != '0) | wr_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven and outputs sampled 1ns after each rising edge.
module tb_regfile_wb_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] d0, d1;
    logic       acc0, acc1;
    logic [7:0] rf [4];

    regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(2), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Register file the arbiter feeds.
    always @(posedge clk) begin
        if (wr_en)
            rf[wr_addr] <= wr_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && busy; i++)
            tick;
        chk(tag, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        tick;
        tick;
        reset = 1'b0;

        // Reset state
        chk("rst_wr_en",   wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_ready0",  req0_ready, 1);
        chk("rst_ready1",  req1_ready, 1);

        // Single request
        req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 8'h5A;
        tick;
        req0_valid = 1'b0;
        chk("single_wr_en_c1", wr_en, 0);
        chk("single_busy_c1",  busy, 1);
        tick;
        chk("single_wr_en_c2", wr_en, 1);
        chk("single_addr_c2",  wr_addr, 2);
        chk("single_data_c2",  wr_data, 8'h5A);
        tick;
        chk("single_wr_en_c3", wr_en, 0);
        chk("single_busy_c3",  busy, 0);
        chk("single_hold_c3",  wr_data, 8'h5A);

        // Contention: writes alternate 0,1,0,1 with wr_en held high
        do_reset;
        d0 = 8'h11; d1 = 8'h33;
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = d0;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = d1;
        tick;
        d0 = d0 + 8'd1; d1 = d1 + 8'd1;
        req0_data = d0; req1_data = d1;
        chk("cont_wr_en_c1", wr_en, 0);
        for (int k = 0; k < 6; k++) begin
            acc0 = req0_ready;
            acc1 = req1_ready;
            tick;
            if (acc0) d0 = d0 + 8'd1;
            if (acc1) d1 = d1 + 8'd1;
            req0_data = d0; req1_data = d1;
            chk("cont_wr_en", wr_en, 1);
            chk("cont_addr",  wr_addr, (k % 2 == 0) ? 32'd1 : 32'd3);
            chk("cont_data",  wr_data, (k % 2 == 0) ? (32'h11 + k / 2) : (32'h33 + k / 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("cont_drain");

        // Queue full: req1 wins while req0 fills; A0,A1,A2 must stay in order
        do_reset;
        req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 8'h55;
        tick;
        req0_addr = 2'd2; req0_data = 8'hA0;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 8'hB0;
        tick;
        chk("full_dummy_data", wr_data, 8'h55);
        req0_data = 8'hA1; req1_data = 8'hB1;
        tick;
        chk("full_b0_data",  wr_data, 8'hB0);
        chk("full_b0_addr",  wr_addr, 3);
        chk("full_ready0_lo", req0_ready, 0);
        chk("full_ready1_hi", req1_ready, 1);
        req0_data = 8'hA2; req1_valid = 1'b0;
        tick;
        chk("full_a0_data",   wr_data, 8'hA0);
        chk("full_ready0_up", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        chk("full_b1_data",   wr_data, 8'hB1);
        chk("full_ready0_lo2", req0_ready, 0);
        tick;
        chk("full_a1_data", wr_data, 8'hA1);
        tick;
        chk("full_a2_data", wr_data, 8'hA2);
        chk("full_a2_addr", wr_addr, 2);
        tick;
        chk("full_idle_wr_en", wr_en, 0);
        chk("full_idle_busy",  busy, 0);

        // Reset mid-operation
        do_reset;
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 8'h61;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'h71;
        tick; tick; tick;
        chk("mid_pre_wr_en", wr_en, 1);
        chk("mid_pre_busy",  busy, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en",   wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_busy",    busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_ready0", req0_ready, 1);
        chk("mid_ready1", req1_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mid_no_stale_wr", wr_en, 0);
        end
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 8'hC0;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'hD0;
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick;
        chk("mid_first_gnt_data", wr_data, 8'hC0);
        chk("mid_first_gnt_addr", wr_addr, 1);
        tick;
        chk("mid_second_gnt_data", wr_data, 8'hD0);
        tick;
        chk("mid_idle_wr_en", wr_en, 0);

        // Same-address writes from one requester
        do_reset;
        req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 8'h01;
        tick;
        req1_data = 8'h02;
        tick;
        req1_valid = 1'b0;
        chk("same_first_data", wr_data, 8'h01);
        chk("same_first_addr", wr_addr, 0);
        tick;
        chk("same_second_data", wr_data, 8'h02);
        chk("same_second_en",   wr_en, 1);
        tick;
        chk("same_rf0_final", rf[0], 8'h02);
        chk("same_idle_wr_en", wr_en, 0);

        // Push and pop on queue 1 in the same cycle
        do_reset;
        req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 8'hE0;
        tick;
        chk("pp_ready_c1", req1_ready, 1);
        req1_data = 8'hE1;
        tick;
        chk("pp_ready_c2", req1_ready, 1);
        chk("pp_data_e0",  wr_data, 8'hE0);
        req1_data = 8'hE2;
        tick;
        chk("pp_ready_c3", req1_ready, 1);
        chk("pp_data_e1",  wr_data, 8'hE1);
        req1_valid = 1'b0;
        tick;
        chk("pp_data_e2", wr_data, 8'hE2);
        chk("pp_wr_en_e2", wr_en, 1);
        tick;
        chk("pp_idle_wr_en", wr_en, 0);
        chk("pp_idle_busy",  busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
